// File: rtl/i4004_bus_timing_if.sv
// i4004_bus_timing_if
//   Bus between the MCS-4 CPU-side timing sequencer and its environment
//   (ROM/RAM chips, fetch logic).
//   master : the sequencer. It reads pc_i, src_*, D_i and drives the bus
//            and the timing outputs.
//   slave  : the environment. It drives pc_i, src_*, D_i and observes the rest.
//   Ports:
//     pc_i[11:0], src_valid_i, src_addr_i[7:0], D_i[3:0] -> into the sequencer
//     D_o[3:0], D_oe_o, PHI1_o, PHI2_o, SYNC_o, CM_ROM_o, CM_RAM_o,
//     state_o[2:0], opr_o[3:0], opa_o[3:0], instr_valid_o  -> out of the sequencer
//   There is no valid/ready handshake on this bus. Every transfer is placed
//   at a fixed subcycle, so the timing outputs are the only qualifiers.
interface i4004_bus_timing_if;
    logic [11:0] pc_i;
    logic        src_valid_i;
    logic [7:0]  src_addr_i;
    logic [3:0]  D_i;
    logic [3:0]  D_o;
    logic        D_oe_o;
    logic        PHI1_o;
    logic        PHI2_o;
    logic        SYNC_o;
    logic        CM_ROM_o;
    logic        CM_RAM_o;
    logic [2:0]  state_o;
    logic [3:0]  opr_o;
    logic [3:0]  opa_o;
    logic        instr_valid_o;

    modport master (
        input  pc_i, src_valid_i, src_addr_i, D_i,
        output D_o, D_oe_o, PHI1_o, PHI2_o, SYNC_o, CM_ROM_o, CM_RAM_o,
               state_o, opr_o, opa_o, instr_valid_o
    );

    modport slave (
        output pc_i, src_valid_i, src_addr_i, D_i,
        input  D_o, D_oe_o, PHI1_o, PHI2_o, SYNC_o, CM_ROM_o, CM_RAM_o,
               state_o, opr_o, opa_o, instr_valid_o
    );
endinterface

// File: rtl/i4004_bus_timing.sv
// i4004_bus_timing
//   CPU-side MCS-4 bus sequencer. A div/slot/subcycle counter chain produces
//   the two-phase clock, the SYNC marker and the A1..X3 machine-cycle state.
//   The sequencer drives the ROM address (A1-A3) and the optional SRC
//   address (X2-X3) onto the 4-bit bus, and it captures the opcode nibbles
//   in M1/M2.
//   Parameter PHASE_DIV : clk_i cycles per phase slot (>= 1).
//   Ports:
//     clk_i    : design clock
//     RESET_i  : synchronous, active-high reset
//     bus      : i4004_bus_timing_if.master (bus, timing and opcode outputs)
//   All outputs are registered from the counter value, so they lag the
//   counter position by one clk.
module i4004_bus_timing #(
    parameter int PHASE_DIV = 2
) (
    input  logic                    clk_i,
    input  logic                    RESET_i,
    i4004_bus_timing_if.master      bus
);
    localparam int DW = (PHASE_DIV > 1) ? $clog2(PHASE_DIV) : 1;
    localparam logic [DW-1:0] DIV_MAX = DW'(PHASE_DIV - 1);

    typedef enum logic [2:0] {A1, A2, A3, M1, M2, X1, X2, X3} subcycle_t;

    subcycle_t     state_q, state_d;
    logic [1:0]    slot_q, slot_d;
    logic [DW-1:0] div_q, div_d;
    logic          div_last;
    logic          boundary;    // counter at slot 0 / div 0 of a subcycle
    logic          sample_end;  // counter at the last clk of a subcycle

    // Counter chain: the state register is kept separate from next-state logic.
    always_ff @(posedge clk_i) begin
        if (RESET_i) begin
            state_q <= A1;
            slot_q  <= 2'd0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
            div_q   <= div_d;
        end
    end

    always_comb begin
        div_last   = (div_q == DIV_MAX);
        boundary   = (div_q == '0) && (slot_q == 2'd0);
        sample_end = div_last && (slot_q == 2'd3);
        div_d      = div_q + DW'(1);
        slot_d     = slot_q;
        state_d    = state_q;
        if (div_last) begin
            div_d  = '0;
            slot_d = slot_q + 2'd1;
            if (slot_q == 2'd3) begin
                state_d = subcycle_t'(state_q + 3'd1);
            end
        end
    end

    logic [11:4] pc_hi_q;       // pc[3:0] goes out directly on the A1 latch edge
    logic        src_v_q;
    logic [7:0]  src_q;
    logic [3:0]  opr_q, opa_q;  // nibbles held until X1 publishes them
    logic [3:0]  d_q;
    logic        oe_q, phi1_q, phi2_q, sync_q, cm_rom_q, cm_ram_q, iv_q;
    logic [2:0]  st_q;
    logic [3:0]  opr_out_q, opa_out_q;

    always_ff @(posedge clk_i) begin
        if (RESET_i) begin
            pc_hi_q   <= '0;
            src_v_q   <= 1'b0;
            src_q     <= '0;
            opr_q     <= '0;
            opa_q     <= '0;
            d_q       <= '0;
            oe_q      <= 1'b0;
            phi1_q    <= 1'b0;
            phi2_q    <= 1'b0;
            sync_q    <= 1'b0;
            cm_rom_q  <= 1'b0;
            cm_ram_q  <= 1'b0;
            iv_q      <= 1'b0;
            st_q      <= '0;
            opr_out_q <= '0;
            opa_out_q <= '0;
        end else begin
            phi1_q   <= (slot_q == 2'd0);
            phi2_q   <= (slot_q == 2'd2);
            sync_q   <= (state_q == X3);
            cm_rom_q <= (state_q == A3);
            cm_ram_q <= (state_q == X2) && src_v_q;
            st_q     <= state_q;
            iv_q     <= (state_q == X1) && boundary;

            if (state_q == M1 && sample_end) opr_q <= bus.D_i;
            if (state_q == M2 && sample_end) opa_q <= bus.D_i;

            // Bus contents change only on subcycle boundaries. This keeps
            // D_o/D_oe_o stable for the whole subcycle.
            if (boundary) begin
                unique case (state_q)
                    A1: begin
                        pc_hi_q <= bus.pc_i[11:4];
                        d_q     <= bus.pc_i[3:0];
                        oe_q    <= 1'b1;
                    end
                    A2: begin
                        d_q  <= pc_hi_q[7:4];
                        oe_q <= 1'b1;
                    end
                    A3: begin
                        d_q  <= pc_hi_q[11:8];
                        oe_q <= 1'b1;
                    end
                    M1, M2: begin
                        d_q  <= 4'h0;
                        oe_q <= 1'b0;
                    end
                    X1: begin
                        src_v_q   <= bus.src_valid_i;
                        src_q     <= bus.src_addr_i;
                        d_q       <= 4'h0;
                        oe_q      <= 1'b0;
                        opr_out_q <= opr_q;
                        opa_out_q <= opa_q;
                    end
                    X2: begin
                        d_q  <= src_v_q ? src_q[7:4] : 4'h0;
                        oe_q <= src_v_q;
                    end
                    X3: begin
                        d_q  <= src_v_q ? src_q[3:0] : 4'h0;
                        oe_q <= src_v_q;
                    end
                    default: begin
                        d_q  <= 4'h0;
                        oe_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.D_o           = d_q;
    assign bus.D_oe_o        = oe_q;
    assign bus.PHI1_o        = phi1_q;
    assign bus.PHI2_o        = phi2_q;
    assign bus.SYNC_o        = sync_q;
    assign bus.CM_ROM_o      = cm_rom_q;
    assign bus.CM_RAM_o      = cm_ram_q;
    assign bus.state_o       = st_q;
    assign bus.opr_o         = opr_out_q;
    assign bus.opa_o         = opa_out_q;
    assign bus.instr_valid_o = iv_q;
endmodule
